step_accumulator: RTL and testbench
===================================

Name: step_accumulator

Overview:
- Parametrised successor to the fixed 4-bit accumulator: a WIDTH-bit running accumulator with add, subtract, load and hold operations.
- Adds wrap or saturate arithmetic, a sticky overflow flag, an accepted-operation counter and a run/done control FSM that stops when the accumulator reaches a programmable limit.
- Sits beside the ALU datapath as the stepping and counting engine for the lab-board demo.

Parameters:
WIDTH, 4, accumulator, step and limit width (>=2)
CNT_WIDTH, 4, width of the accepted-operation counter
SATURATE, 0, 0 = modulo-2^WIDTH wrap, 1 = clamp to 0 / 2^WIDTH-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  pulse: clear state and enter RUN
en  in  1  step valid; op/step sampled when en=1 in RUN
op  in  2  00 ADD, 01 SUB, 10 LOAD, 11 HOLD
step  in  WIDTH  operand
limit  in  WIDTH  terminal value; sampled every cycle
acc_o  out  WIDTH  accumulator value
count_o  out  CNT_WIDTH  number of accepted ops; saturates at all-ones
ovf_o  out  1  sticky carry/borrow flag
zero_o  out  1  acc_o == 0 (combinational from register)
run_o  out  1  state == RUN
done_o  out  1  state == DONE

Behaviour:
- Reset (reset=0, async):
  - acc_o=0, count_o=0, ovf_o=0, state IDLE.
  - Outputs change immediately, without waiting for a clock edge.
  - A reset in mid-operation abandons the run; no partial update is kept.
- FSM states: IDLE, RUN, DONE.
  - start=1 in any state, next edge: acc=0, count=0, ovf=0, state RUN.
  - start has priority over en in the same cycle; that cycle's op is dropped.
  - In RUN with en=1, the op is accepted (see operations below).
  - RUN->DONE on the edge that accepts an op whose result == limit.
  - In IDLE and DONE, en is ignored and all registers hold.
  - The only exits from IDLE or DONE are start or reset.
- Accepted op, result visible on acc_o at the next rising edge (latency 1). Computation is WIDTH+1 bits:
  - ADD: sum = acc + step. Carry out sets ovf. Result = sum mod 2^WIDTH, or 2^WIDTH-1 if SATURATE and carry.
  - SUB: diff = acc - step. Borrow (step > acc, unsigned) sets ovf. Result = diff mod 2^WIDTH, or 0 if SATURATE and borrow.
  - LOAD: acc = step; ovf unaffected.
  - HOLD: acc unchanged.
  - Every accepted op, including HOLD, increments count. count holds at 2^CNT_WIDTH-1 with no wrap.
  - The limit compare uses the post-wrap/post-clamp result.
    - HOLD with acc == limit also triggers DONE.
    - LOAD of the limit value also triggers DONE.
- ovf is sticky: cleared only by start or reset.
- done_o is asserted on the same edge that acc_o shows the terminal value.
- All arithmetic is unsigned.

Decomposition:
- Shared package step_acc_pkg:
  - op encodings (OP_ADD, OP_SUB, OP_LOAD, OP_HOLD);
  - state encodings (ST_IDLE, ST_RUN, ST_DONE).
- One combinational sub-module, acc_alu:
  - inputs: acc, step, op, SATURATE;
  - outputs: result[WIDTH-1:0], ovf_set.
- The top level holds the FSM, registers, counter and limit compare.

Test Plan:
1. W=4, SATURATE=0, limit=9: start, then three en cycles of ADD step=3 -> acc_o 3,6,9; done_o=1 on the third edge; count_o=3; a further en with ADD 3 leaves acc_o=9 and count_o=3.
2. Wrap, limit=15: start, then ADD 7 three times -> acc_o 7,14,5; ovf_o=1 from the third edge; a following LOAD 2 gives acc_o=2 with ovf_o still 1; run_o stays 1.
3. SATURATE=1, limit=15: ADD 7, 7, 7 -> acc_o 7,14,15 with ovf_o=1 and done_o=1. A separate run of LOAD 2 then SUB 3 -> acc_o 0 with ovf_o=1; the same SUB with SATURATE=0 gives acc_o=15.
4. Simultaneous events: in RUN with acc=6, assert start and en (ADD 3) together -> next edge acc_o=0, count_o=0, ovf_o=0, run_o=1.
5. Reset mid-run: acc=5, count=2, pull reset low between clock edges -> acc_o, count_o, ovf_o, run_o and done_o all read 0 before the next edge; en pulses after reset release without start leave acc_o=0.
6. Counter saturation, CNT_WIDTH=2, limit=15: 5 accepted HOLD ops with acc=0 -> count_o steps 1,2,3,3,3; done_o stays 0.

Source files
------------

// File: rtl/step_acc_pkg.sv
// Shared encodings for the step accumulator: operation codes and control FSM states.
package step_acc_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_HOLD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/step_accumulator_alu.sv
// Combinational next-value unit: applies one op to the accumulator with wrap or clamp.
module acc_alu
  import step_acc_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] step,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             ovf_set
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, acc} + {1'b0, step};
  // Top bit of the (WIDTH+1)-bit difference is the unsigned borrow.
  assign diff = {1'b0, acc} - {1'b0, step};

  always_comb begin
    result  = acc;
    ovf_set = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        ovf_set = sum[WIDTH];
        if (SATURATE != 0 && sum[WIDTH]) result = '1;
        else                             result = sum[WIDTH-1:0];
      end
      OP_SUB: begin
        ovf_set = diff[WIDTH];
        if (SATURATE != 0 && diff[WIDTH]) result = '0;
        else                              result = diff[WIDTH-1:0];
      end
      OP_LOAD: result = step;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/step_accumulator.sv
// Running accumulator with run/done control: steps until the result equals the limit.
module step_accumulator
  import step_acc_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 4,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 en,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     step,
  input  logic [WIDTH-1:0]     limit,
  output logic [WIDTH-1:0]     acc_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 ovf_o,
  output logic                 zero_o,
  output logic                 run_o,
  output logic                 done_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]     acc_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic                 ovf_reg;
  state_t               state_reg;

  logic [WIDTH-1:0]     alu_result;
  logic                 alu_ovf;

  acc_alu #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_alu (
    .acc     (acc_reg),
    .step    (step),
    .op      (op),
    .result  (alu_result),
    .ovf_set (alu_ovf)
  );

  // start wins over en, so an op presented alongside start is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      state_reg <= ST_IDLE;
    end else if (start) begin
      acc_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      state_reg <= ST_RUN;
    end else if (state_reg == ST_RUN && en) begin
      acc_reg <= alu_result;
      ovf_reg <= ovf_reg | alu_ovf;
      if (count_reg != CNT_MAX) count_reg <= count_reg + 1'b1;
      if (alu_result == limit) state_reg <= ST_DONE;
    end
  end

  assign acc_o   = acc_reg;
  assign count_o = count_reg;
  assign ovf_o   = ovf_reg;
  assign zero_o  = (acc_reg == '0);
  assign run_o   = (state_reg == ST_RUN);
  assign done_o  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_step_accumulator.sv
// Bench: three accumulator variants (wrap, saturate, 2-bit counter) driven in lockstep.
module tb_step_accumulator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       en = 1'b0;
  logic [1:0] op = 2'b00;
  logic [3:0] step = 4'd0;
  logic [3:0] limit = 4'd0;

  logic [3:0] acc0, acc1, acc2;
  logic [3:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic ovf0, ovf1, ovf2, zero0, zero1, zero2;
  logic run0, run1, run2, done0, done1, done2;

  always #5 clk = ~clk;

  step_accumulator #(.WIDTH(4), .CNT_WIDTH(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .en(en), .op(op), .step(step), .limit(limit),
    .acc_o(acc0), .count_o(cnt0), .ovf_o(ovf0), .zero_o(zero0), .run_o(run0), .done_o(done0));

  step_accumulator #(.WIDTH(4), .CNT_WIDTH(4), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .en(en), .op(op), .step(step), .limit(limit),
    .acc_o(acc1), .count_o(cnt1), .ovf_o(ovf1), .zero_o(zero1), .run_o(run1), .done_o(done1));

  step_accumulator #(.WIDTH(4), .CNT_WIDTH(2), .SATURATE(0)) dut_cnt2 (
    .clk(clk), .reset(reset), .start(start), .en(en), .op(op), .step(step), .limit(limit),
    .acc_o(acc2), .count_o(cnt2), .ovf_o(ovf2), .zero_o(zero2), .run_o(run2), .done_o(done2));

  int total = 0;
  int passed = 0;

  // Reference model: integer arithmetic straight from the operation rules.
  int m_acc[3], m_cnt[3], m_ovf[3], m_run[3], m_done[3];
  int m_sat[3]  = '{0, 1, 0};
  int m_cmax[3] = '{15, 15, 3};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_run[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_step();
    int res;
    for (int i = 0; i < 3; i++) begin
      if (start) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_run[i] = 1; m_done[i] = 0;
      end else if (m_run[i] == 1 && en) begin
        case (op)
          2'd0: begin
            res = m_acc[i] + int'(step);
            if (res > 15) begin m_ovf[i] = 1; res = (m_sat[i] != 0) ? 15 : res - 16; end
          end
          2'd1: begin
            res = m_acc[i] - int'(step);
            if (res < 0) begin m_ovf[i] = 1; res = (m_sat[i] != 0) ? 0 : res + 16; end
          end
          2'd2: res = int'(step);
          default: res = m_acc[i];
        endcase
        if (m_cnt[i] < m_cmax[i]) m_cnt[i] = m_cnt[i] + 1;
        if (res == int'(limit)) begin m_run[i] = 0; m_done[i] = 1; end
        m_acc[i] = res;
      end
    end
  endtask

  task automatic check_models();
    int a[3], c[3], v[3], z[3], r[3], d[3];
    a = '{int'(acc0), int'(acc1), int'(acc2)};
    c = '{int'(cnt0), int'(cnt1), int'(cnt2)};
    v = '{int'(ovf0), int'(ovf1), int'(ovf2)};
    z = '{int'(zero0), int'(zero1), int'(zero2)};
    r = '{int'(run0), int'(run1), int'(run2)};
    d = '{int'(done0), int'(done1), int'(done2)};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model acc[%0d]", i), a[i], m_acc[i]);
      chk($sformatf("model count[%0d]", i), c[i], m_cnt[i]);
      chk($sformatf("model ovf[%0d]", i), v[i], m_ovf[i]);
      chk($sformatf("model zero[%0d]", i), z[i], (m_acc[i] == 0) ? 1 : 0);
      chk($sformatf("model run[%0d]", i), r[i], m_run[i]);
      chk($sformatf("model done[%0d]", i), d[i], m_done[i]);
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input logic s, input logic e, input logic [1:0] o,
                       input logic [3:0] st, input logic [3:0] lim);
    start = s; en = e; op = o; step = st; limit = lim;
    model_step();
    @(posedge clk);
    #1;
    check_models();
  endtask

  // Reset pulse between clock edges; outputs must clear before any edge.
  task automatic mid_reset();
    #3 reset = 1'b0;
    model_reset();
    #1;
    check_models();
    chk("async acc", int'(acc0), 0);
    chk("async run", int'(run0), 0);
    #2 reset = 1'b1;
  endtask

  typedef struct {
    logic s, e;
    logic [1:0] o;
    logic [3:0] st, lim;
    int acc, cnt, ovf, run, done;
    int sacc, sovf, sdone;
  } vec_t;

  function automatic vec_t mk(logic s, logic e, logic [1:0] o, logic [3:0] st, logic [3:0] lim,
                              int acc, int cnt, int ovf, int run, int done,
                              int sacc, int sovf, int sdone);
    vec_t v;
    v.s = s; v.e = e; v.o = o; v.st = st; v.lim = lim;
    v.acc = acc; v.cnt = cnt; v.ovf = ovf; v.run = run; v.done = done;
    v.sacc = sacc; v.sovf = sovf; v.sdone = sdone;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    // Stepping to limit 9, then extra op ignored in DONE.
    vt.push_back(mk(1, 0, 2'd0, 4'd0, 4'd9,  0, 0, 0, 1, 0,   0, 0, 0));
    vt.push_back(mk(0, 1, 2'd0, 4'd3, 4'd9,  3, 1, 0, 1, 0,   3, 0, 0));
    vt.push_back(mk(0, 1, 2'd0, 4'd3, 4'd9,  6, 2, 0, 1, 0,   6, 0, 0));
    vt.push_back(mk(0, 1, 2'd0, 4'd3, 4'd9,  9, 3, 0, 0, 1,   9, 0, 1));
    vt.push_back(mk(0, 1, 2'd0, 4'd3, 4'd9,  9, 3, 0, 0, 1,   9, 0, 1));
    // Wrap vs saturate on repeated ADD 7, limit 15.
    vt.push_back(mk(1, 0, 2'd0, 4'd0, 4'd15, 0, 0, 0, 1, 0,   0, 0, 0));
    vt.push_back(mk(0, 1, 2'd0, 4'd7, 4'd15, 7, 1, 0, 1, 0,   7, 0, 0));
    vt.push_back(mk(0, 1, 2'd0, 4'd7, 4'd15, 14, 2, 0, 1, 0,  14, 0, 0));
    vt.push_back(mk(0, 1, 2'd0, 4'd7, 4'd15, 5, 3, 1, 1, 0,   15, 1, 1));
    vt.push_back(mk(0, 1, 2'd2, 4'd2, 4'd15, 2, 4, 1, 1, 0,   15, 1, 1));
    // LOAD 2 then SUB 3: wrap reaches 15 (== limit), clamp gives 0.
    vt.push_back(mk(1, 0, 2'd0, 4'd0, 4'd15, 0, 0, 0, 1, 0,   0, 0, 0));
    vt.push_back(mk(0, 1, 2'd2, 4'd2, 4'd15, 2, 1, 0, 1, 0,   2, 0, 0));
    vt.push_back(mk(0, 1, 2'd1, 4'd3, 4'd15, 15, 2, 1, 0, 1,  0, 1, 0));

    // Power-up reset check.
    model_reset();
    #1 reset = 1'b0;
    #1;
    check_models();
    #5 reset = 1'b1;

    foreach (vt[k]) begin
      cycle(vt[k].s, vt[k].e, vt[k].o, vt[k].st, vt[k].lim);
      chk($sformatf("vec%0d acc", k), int'(acc0), vt[k].acc);
      chk($sformatf("vec%0d count", k), int'(cnt0), vt[k].cnt);
      chk($sformatf("vec%0d ovf", k), int'(ovf0), vt[k].ovf);
      chk($sformatf("vec%0d run", k), int'(run0), vt[k].run);
      chk($sformatf("vec%0d done", k), int'(done0), vt[k].done);
      chk($sformatf("vec%0d sat acc", k), int'(acc1), vt[k].sacc);
      chk($sformatf("vec%0d sat ovf", k), int'(ovf1), vt[k].sovf);
      chk($sformatf("vec%0d sat done", k), int'(done1), vt[k].sdone);
    end

    // start and en together: op dropped, state cleared.
    cycle(1, 0, 2'd0, 4'd0, 4'd15);
    cycle(0, 1, 2'd2, 4'd6, 4'd15);
    chk("pre-start acc", int'(acc0), 6);
    cycle(1, 1, 2'd0, 4'd3, 4'd15);
    chk("start+en acc", int'(acc0), 0);
    chk("start+en count", int'(cnt0), 0);
    chk("start+en ovf", int'(ovf0), 0);
    chk("start+en run", int'(run0), 1);

    // Reset mid-run, then en without start must do nothing.
    cycle(0, 1, 2'd2, 4'd5, 4'd15);
    cycle(0, 1, 2'd3, 4'd0, 4'd15);
    chk("pre-reset acc", int'(acc0), 5);
    chk("pre-reset count", int'(cnt0), 2);
    mid_reset();
    chk("async count", int'(cnt0), 0);
    chk("async done", int'(done0), 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 2'd0, 4'd3, 4'd15);
      chk("idle en acc", int'(acc0), 0);
    end

    // 2-bit counter saturates on HOLD ops.
    cycle(1, 0, 2'd0, 4'd0, 4'd15);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 2'd3, 4'd0, 4'd15);
      chk($sformatf("cnt2 hold%0d count", k), int'(cnt2), (k < 3) ? k + 1 : 3);
      chk($sformatf("cnt2 hold%0d done", k), int'(done2), 0);
    end

    // Randomised traffic against the model, with occasional restarts and resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) mid_reset();
      cycle(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
